// File: rtl/matrix_result_serializer_if.sv
// Element stream between the matrix result serializer (master) and the print path (slave).
// Carries one matrix element per valid/ready transfer together with its position and row/matrix end flags.
interface matrix_result_serializer_if #(
    parameter int ELEM_W = 8
);
    logic              elem_valid;
    logic              elem_ready;
    logic [ELEM_W-1:0] elem_data;
    logic [2:0]        elem_row;
    logic [2:0]        elem_col;
    logic              row_end;
    logic              elem_last;

    modport master (
        output elem_valid,
        output elem_data,
        output elem_row,
        output elem_col,
        output row_end,
        output elem_last,
        input  elem_ready
    );

    modport slave (
        input  elem_valid,
        input  elem_data,
        input  elem_row,
        input  elem_col,
        input  row_end,
        input  elem_last,
        output elem_ready
    );
endinterface

// File: rtl/matrix_result_serializer.sv
// Captures one matrix of a packed pair plus its dims and streams it row-major over valid/ready.
// Optional macro MATRIX_SERIALIZER_SEL_EN adds mat_sel to choose which slot is streamed.
module matrix_result_serializer #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       src_valid,
    input  logic [2:0]                 m_in,
    input  logic [2:0]                 n_in,
    input  logic [2*MAT_W-1:0]         matrices_in,
`ifdef MATRIX_SERIALIZER_SEL_EN
    input  logic                       mat_sel,
`endif
    input  logic                       abort,
    matrix_result_serializer_if.master stream,
    output logic                       busy,
    output logic                       err
);

    localparam int CELLS = MAX_DIM * MAX_DIM;
    localparam int IDX_W = $clog2(CELLS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [MAT_W-1:0]  mat_reg;
    logic [2:0]        m_reg;
    logic [2:0]        n_reg;
    logic [2:0]        row;
    logic [2:0]        col;
    logic              err_q;

    logic              sending;
    logic              dims_ok;
    logic              at_row_end;
    logic              at_last;
    logic [MAT_W-1:0]  slot_sel;
    logic [IDX_W-1:0]  elem_idx;
    logic [ELEM_W-1:0] cells [CELLS];

`ifdef MATRIX_SERIALIZER_SEL_EN
    assign slot_sel = mat_sel ? matrices_in[MAT_W +: MAT_W] : matrices_in[0 +: MAT_W];
`else
    // Slot 1 is never streamed in this build; the reduction keeps it visibly consumed.
    logic unused_upper_slot;
    assign unused_upper_slot = ^matrices_in[2*MAT_W-1:MAT_W];
    assign slot_sel          = matrices_in[0 +: MAT_W];
`endif

    assign dims_ok = (m_in != 3'd0) && (n_in != 3'd0)
                  && (int'(m_in) <= MAX_DIM) && (int'(n_in) <= MAX_DIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mat_reg <= '0;
            m_reg   <= '0;
            n_reg   <= '0;
            row     <= '0;
            col     <= '0;
            err_q   <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && src_valid) begin
                        if (dims_ok) begin
                            mat_reg <= slot_sel;
                            m_reg   <= m_in;
                            n_reg   <= n_in;
                            row     <= '0;
                            col     <= '0;
                            state   <= SEND;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (stream.elem_ready) begin
                        if (at_last) begin
                            state <= DONE;
                        end else if (at_row_end) begin
                            col <= '0;
                            row <= row + 3'd1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Flat view of the captured matrix so the current element is a simple array read.
    for (genvar i = 0; i < CELLS; i++) begin : g_cells
        assign cells[i] = mat_reg[i*ELEM_W +: ELEM_W];
    end

    assign elem_idx   = IDX_W'(row) * IDX_W'(MAX_DIM) + IDX_W'(col);
    assign sending    = (state == SEND);
    assign at_row_end = (col == n_reg - 3'd1);
    assign at_last    = at_row_end && (row == m_reg - 3'd1);

    assign stream.elem_valid = sending;
    assign stream.elem_data  = sending ? cells[elem_idx] : '0;
    assign stream.elem_row   = sending ? row : '0;
    assign stream.elem_col   = sending ? col : '0;
    assign stream.row_end    = sending && at_row_end;
    assign stream.elem_last  = sending && at_last;
    assign busy              = (state != IDLE);
    assign err               = err_q;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: reset, streams with backpressure, illegal dims, abort, slot select.
// Honours MATRIX_SERIALIZER_SEL_EN the same way the design does.
module tb_matrix_result_serializer;

    logic         clk;
    logic         reset;
    logic         start;
    logic         src_valid;
    logic [2:0]   m_in;
    logic [2:0]   n_in;
    logic [399:0] matrices_in;
    logic         abort;
    logic         busy;
    logic         err;
`ifdef MATRIX_SERIALIZER_SEL_EN
    logic         mat_sel;
`endif

    int checks = 0;
    int errors = 0;

    matrix_result_serializer_if #(.ELEM_W(8)) stream ();

    matrix_result_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_valid   (src_valid),
        .m_in        (m_in),
        .n_in        (n_in),
        .matrices_in (matrices_in),
`ifdef MATRIX_SERIALIZER_SEL_EN
        .mat_sel     (mat_sel),
`endif
        .abort       (abort),
        .stream      (stream.master),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_elem(input int slot, input int r, input int c, input logic [7:0] v);
        matrices_in[slot*200 + (r*5 + c)*8 +: 8] = v;
    endtask

    task automatic apply_stimulus(input logic [2:0] m, input logic [2:0] n);
        m_in      = m;
        n_in      = n;
        start     = 1'b1;
        src_valid = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_valid"}, 32'(stream.elem_valid), 32'd0);
        check_output({tag, "_busy"},  32'(busy),              32'd0);
    endtask

    initial begin
        int exp_idx;
        logic ready_pat [3];
        ready_pat = '{1'b1, 1'b0, 1'b0};

        reset       = 1'b0;
        start       = 1'b0;
        src_valid   = 1'b0;
        m_in        = 3'd0;
        n_in        = 3'd0;
        matrices_in = '0;
        abort       = 1'b0;
        stream.elem_ready = 1'b0;
`ifdef MATRIX_SERIALIZER_SEL_EN
        mat_sel     = 1'b0;
`endif
        step();
        step();
        reset = 1'b1;
        step();

        $display("[TB] reset and idle");
        check_idle("rst");
        check_output("rst_err",     32'(err),              32'd0);
        check_output("rst_data",    32'(stream.elem_data), 32'd0);
        check_output("rst_row_end", 32'(stream.row_end),   32'd0);
        check_output("rst_last",    32'(stream.elem_last), 32'd0);

        m_in  = 3'd1;
        n_in  = 3'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check_idle("nosrc");
        check_output("nosrc_err", 32'(err), 32'd0);

        $display("[TB] 3x1 stream");
        set_elem(0, 0, 0, 8'd1);
        set_elem(0, 1, 0, 8'd2);
        set_elem(0, 2, 0, 8'd3);
        set_elem(0, 0, 1, 8'd99);
        stream.elem_ready = 1'b1;
        apply_stimulus(3'd3, 3'd1);
        src_valid = 1'b0;
        set_elem(0, 1, 0, 8'd77);
        m_in = 3'd5;
        n_in = 3'd5;
        for (int b = 0; b < 3; b++) begin
            check_output("c31_valid",   32'(stream.elem_valid), 32'd1);
            check_output("c31_data",    32'(stream.elem_data),  32'(b + 1));
            check_output("c31_row",     32'(stream.elem_row),   32'(b));
            check_output("c31_col",     32'(stream.elem_col),   32'd0);
            check_output("c31_row_end", 32'(stream.row_end),    32'd1);
            check_output("c31_last",    32'(stream.elem_last),  32'(b == 2));
            step();
        end
        check_output("c31_done_valid", 32'(stream.elem_valid), 32'd0);
        check_output("c31_done_busy",  32'(busy),              32'd1);
        step();
        check_idle("c31_idle");

        $display("[TB] 2x3 with backpressure");
        for (int i = 0; i < 6; i++) set_elem(0, i / 3, i % 3, 8'(10 + i));
        stream.elem_ready = 1'b1;
        apply_stimulus(3'd2, 3'd3);
        src_valid = 1'b0;
        exp_idx = 0;
        for (int cyc = 0; cyc < 60 && exp_idx < 6; cyc++) begin
            check_output("bp_valid",   32'(stream.elem_valid), 32'd1);
            check_output("bp_data",    32'(stream.elem_data),  32'(10 + exp_idx));
            check_output("bp_row",     32'(stream.elem_row),   32'(exp_idx / 3));
            check_output("bp_col",     32'(stream.elem_col),   32'(exp_idx % 3));
            check_output("bp_row_end", 32'(stream.row_end),    32'(exp_idx % 3 == 2));
            check_output("bp_last",    32'(stream.elem_last),  32'(exp_idx == 5));
            stream.elem_ready = ready_pat[cyc % 3];
            step();
            if (stream.elem_ready) exp_idx++;
        end
        check_output("bp_count",      32'(exp_idx),           32'd6);
        check_output("bp_done_valid", 32'(stream.elem_valid), 32'd0);
        check_output("bp_done_busy",  32'(busy),              32'd1);
        apply_stimulus(3'd1, 3'd1);
        src_valid = 1'b0;
        check_idle("bp_done_start");
        step();
        check_idle("bp_no_queue");

        $display("[TB] illegal dims");
        apply_stimulus(3'd0, 3'd3);
        src_valid = 1'b0;
        check_output("ill0_err", 32'(err), 32'd1);
        check_idle("ill0");
        step();
        check_output("ill0_err_clr", 32'(err), 32'd0);
        apply_stimulus(3'd6, 3'd2);
        src_valid = 1'b0;
        check_output("ill6_err", 32'(err), 32'd1);
        check_idle("ill6");
        step();
        check_output("ill6_err_clr", 32'(err), 32'd0);
        check_idle("ill6_after");

        $display("[TB] abort and restart");
        for (int i = 0; i < 25; i++) set_elem(0, i / 5, i % 5, 8'(i + 1));
        stream.elem_ready = 1'b1;
        apply_stimulus(3'd5, 3'd5);
        src_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check_output("ab_data", 32'(stream.elem_data), 32'(b + 1));
            step();
        end
        check_output("ab_beat5_data",    32'(stream.elem_data), 32'd5);
        check_output("ab_beat5_row_end", 32'(stream.row_end),   32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("ab");
        check_output("ab_row_end", 32'(stream.row_end),   32'd0);
        check_output("ab_last",    32'(stream.elem_last), 32'd0);
        step();
        check_idle("ab_stay");
        set_elem(0, 0, 0, 8'hA5);
        apply_stimulus(3'd1, 3'd1);
        src_valid = 1'b0;
        check_output("r11_valid",   32'(stream.elem_valid), 32'd1);
        check_output("r11_data",    32'(stream.elem_data),  32'hA5);
        check_output("r11_row_end", 32'(stream.row_end),    32'd1);
        check_output("r11_last",    32'(stream.elem_last),  32'd1);
        step();
        check_output("r11_done_busy",  32'(busy),              32'd1);
        check_output("r11_done_valid", 32'(stream.elem_valid), 32'd0);
        step();
        check_idle("r11_idle");

        $display("[TB] slot select");
        set_elem(1, 0, 0, 8'd7);
        set_elem(0, 0, 0, 8'd9);
`ifdef MATRIX_SERIALIZER_SEL_EN
        mat_sel = 1'b1;
        apply_stimulus(3'd1, 3'd1);
        src_valid = 1'b0;
        mat_sel = 1'b0;
        check_output("sel1_data", 32'(stream.elem_data), 32'd7);
        step();
        step();
        apply_stimulus(3'd1, 3'd1);
        src_valid = 1'b0;
        check_output("sel0_data", 32'(stream.elem_data), 32'd9);
        step();
        step();
`else
        apply_stimulus(3'd1, 3'd1);
        src_valid = 1'b0;
        check_output("slot0_data", 32'(stream.elem_data), 32'd9);
        step();
        step();
`endif

        $display("[TB] async reset mid-stream");
        stream.elem_ready = 1'b0;
        apply_stimulus(3'd2, 3'd2);
        src_valid = 1'b0;
        check_output("ar_valid_before", 32'(stream.elem_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_idle("ar");
        check_output("ar_data", 32'(stream.elem_data), 32'd0);
        step();
        reset = 1'b1;
        step();
        check_idle("ar_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
